// File: rtl/irq_priority_sequencer.sv
// Rotating-priority interrupt sequencer with in-service nesting and a two-pulse
// acknowledge handshake. Optional polled acknowledge is built when IRQ_POLL_EN is defined.
module irq_priority_sequencer #(
    parameter int NUM_IRQ  = 8,
    parameter int VECTOR_W = 8,
    localparam int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq_req,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_addr,
    input  logic [31:0]         cfg_wdata,
    input  logic                ack_n,
    output logic                int_out,
    output logic                vec_valid,
    output logic [VECTOR_W-1:0] vec_data,
    output logic [NUM_IRQ-1:0]  isr,
    output logic [NUM_IRQ-1:0]  imr,
    input  logic                poll_req,
    output logic                poll_valid,
    output logic [ID_W:0]       poll_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK1 = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_ACK2 = 2'd3;

    localparam logic [NUM_IRQ-1:0]  ONE_VEC     = NUM_IRQ'(1);
    localparam logic [NUM_IRQ-1:0]  ZERO_VEC    = {NUM_IRQ{1'b0}};
    localparam logic [ID_W-1:0]     SPUR_ID     = ID_W'(NUM_IRQ - 1);
    localparam logic [VECTOR_W-1:0] VEC_HI_MASK = {VECTOR_W{1'b1}} << ID_W;

    // Rotate so that bit 0 of the result is channel 'sh' (the highest-priority id).
    function automatic logic [NUM_IRQ-1:0] rotate_down(input logic [NUM_IRQ-1:0] v,
                                                        input logic [ID_W-1:0]    sh);
        logic [2*NUM_IRQ-1:0] d;
        d = {v, v} >> sh;
        return d[NUM_IRQ-1:0];
    endfunction

    // Returns {hit, rank} of the lowest set bit, rank 0 being the highest priority.
    function automatic logic [ID_W:0] first_set(input logic [NUM_IRQ-1:0] v);
        logic [ID_W:0] r;
        r = {(ID_W+1){1'b0}};
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (v[k]) begin
                r = {1'b1, ID_W'(k)};
            end
        end
        return r;
    endfunction

    logic [1:0]          state_r;
    logic                ack_prev_r;
    logic                ack_armed_r;
    logic [NUM_IRQ-1:0]  isr_r;
    logic [NUM_IRQ-1:0]  imr_r;
    logic [VECTOR_W-1:0] vbase_r;
    logic                auto_eoi_r;
    logic                auto_rot_r;
    logic [ID_W-1:0]     prio_low_r;
    logic [ID_W-1:0]     ack_id_r;
    logic                spurious_r;
    logic                int_out_r;
    logic                vec_valid_r;
    logic [VECTOR_W-1:0] vec_data_r;
    logic                poll_valid_r;
    logic [ID_W:0]       poll_data_r;

    logic [1:0]          state_nx_s;
    logic [ID_W-1:0]     start_s;
    logic                win_hit_s;
    logic [ID_W-1:0]     win_rank_s;
    logic [ID_W-1:0]     win_id_s;
    logic                isr_hit_s;
    logic [ID_W-1:0]     isr_rank_s;
    logic [ID_W-1:0]     isr_id_s;
    logic                fall_s;
    logic                rise_s;
    logic                accept_s;
    logic                leave_s;
    logic                latch_s;
    logic                poll_fire_s;
    logic                cfg_eoi_s;
    logic                eoi_tgt_hit_s;
    logic [ID_W-1:0]     eoi_tgt_id_s;
    logic [NUM_IRQ-1:0]  isr_set_s;
    logic [NUM_IRQ-1:0]  eoi_clr_s;
    logic [NUM_IRQ-1:0]  auto_clr_s;
    logic [NUM_IRQ-1:0]  isr_nx_s;
    logic [ID_W-1:0]     prio_nx_s;
    logic                int_nx_s;
    logic                vec_valid_nx_s;
    logic [VECTOR_W-1:0] vec_data_nx_s;
    logic                unused_s;

    assign start_s = prio_low_r + ID_W'(1);
    assign {win_hit_s, win_rank_s} = first_set(rotate_down(irq_req & ~imr_r, start_s));
    assign win_id_s = start_s + win_rank_s;
    assign {isr_hit_s, isr_rank_s} = first_set(rotate_down(isr_r, start_s));
    assign isr_id_s = start_s + isr_rank_s;

    // A low ack_n still pending when reset releases must not count as a fall.
    assign fall_s   = ack_armed_r & ack_prev_r & ~ack_n;
    assign rise_s   = ~ack_prev_r & ack_n;
    assign accept_s = (state_r == ST_IDLE) && fall_s;
    assign leave_s  = (state_r == ST_ACK2) && rise_s;

`ifdef IRQ_POLL_EN
    assign poll_fire_s = poll_req && (state_r == ST_IDLE);
`else
    assign poll_fire_s = 1'b0;
`endif
    assign latch_s = accept_s | poll_fire_s;

    assign cfg_eoi_s     = cfg_we && (cfg_addr == 2'd3);
    assign eoi_tgt_hit_s = cfg_wdata[8] | isr_hit_s;
    assign eoi_tgt_id_s  = cfg_wdata[8] ? cfg_wdata[ID_W-1:0] : isr_id_s;

    // Set is OR-ed in after clearing, so a same-bit set/clear collision keeps the bit.
    assign isr_set_s  = (latch_s && win_hit_s) ? (ONE_VEC << win_id_s) : ZERO_VEC;
    assign eoi_clr_s  = (cfg_eoi_s && eoi_tgt_hit_s) ? (ONE_VEC << eoi_tgt_id_s) : ZERO_VEC;
    assign auto_clr_s = (leave_s && !spurious_r && auto_eoi_r) ? (ONE_VEC << ack_id_r) : ZERO_VEC;
    assign isr_nx_s   = (isr_r & ~(eoi_clr_s | auto_clr_s)) | isr_set_s;

    assign unused_s = ^{poll_req, cfg_wdata};

    // Acknowledge handshake state sequencing.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: if (fall_s) state_nx_s = ST_ACK1; else state_nx_s = ST_IDLE;
            ST_ACK1: if (rise_s) state_nx_s = ST_GAP;  else state_nx_s = ST_ACK1;
            ST_GAP:  if (fall_s) state_nx_s = ST_ACK2; else state_nx_s = ST_GAP;
            ST_ACK2: if (rise_s) state_nx_s = ST_IDLE; else state_nx_s = ST_ACK2;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Rotation source: an explicit EOI rotate takes precedence over auto-rotate.
    always_comb begin
        prio_nx_s = prio_low_r;
        if (cfg_eoi_s && eoi_tgt_hit_s && cfg_wdata[9]) begin
            prio_nx_s = eoi_tgt_id_s;
        end else if (leave_s && !spurious_r && auto_rot_r) begin
            prio_nx_s = ack_id_r;
        end else begin
            prio_nx_s = prio_low_r;
        end
    end

    // Next values for the registered CPU-facing outputs.
    always_comb begin
        int_nx_s       = 1'b0;
        vec_valid_nx_s = 1'b0;
        vec_data_nx_s  = {VECTOR_W{1'b0}};
        if ((state_r == ST_IDLE) && win_hit_s && (!isr_hit_s || (win_rank_s < isr_rank_s))) begin
            int_nx_s = 1'b1;
        end else begin
            int_nx_s = 1'b0;
        end
        if ((state_nx_s == ST_ACK2) && !ack_n) begin
            vec_valid_nx_s = 1'b1;
            vec_data_nx_s  = (vbase_r & VEC_HI_MASK) | VECTOR_W'(ack_id_r);
        end else begin
            vec_valid_nx_s = 1'b0;
            vec_data_nx_s  = {VECTOR_W{1'b0}};
        end
    end

    // Sequencer state, acknowledge capture and in-service tracking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ack_prev_r  <= 1'b1;
            ack_armed_r <= 1'b0;
            isr_r       <= ZERO_VEC;
            prio_low_r  <= SPUR_ID;
            ack_id_r    <= {ID_W{1'b0}};
            spurious_r  <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            ack_prev_r  <= ack_n;
            ack_armed_r <= ack_armed_r | ack_n;
            isr_r       <= isr_nx_s;
            prio_low_r  <= prio_nx_s;
            if (latch_s) begin
                ack_id_r   <= win_hit_s ? win_id_s : SPUR_ID;
                spurious_r <= ~win_hit_s;
            end
        end
    end

    // Configuration registers; address 3 is a command handled above.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            imr_r      <= {NUM_IRQ{1'b1}};
            vbase_r    <= {VECTOR_W{1'b0}};
            auto_eoi_r <= 1'b0;
            auto_rot_r <= 1'b0;
        end else if (cfg_we) begin
            case (cfg_addr)
                2'd0: imr_r   <= cfg_wdata[NUM_IRQ-1:0];
                2'd1: vbase_r <= cfg_wdata[VECTOR_W-1:0];
                2'd2: begin
                    auto_eoi_r <= cfg_wdata[0];
                    auto_rot_r <= cfg_wdata[1];
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            int_out_r    <= 1'b0;
            vec_valid_r  <= 1'b0;
            vec_data_r   <= {VECTOR_W{1'b0}};
            poll_valid_r <= 1'b0;
            poll_data_r  <= {(ID_W+1){1'b0}};
        end else begin
            int_out_r    <= int_nx_s;
            vec_valid_r  <= vec_valid_nx_s;
            vec_data_r   <= vec_data_nx_s;
            poll_valid_r <= poll_fire_s;
            poll_data_r  <= (poll_fire_s && win_hit_s) ? {1'b1, win_id_s} : {(ID_W+1){1'b0}};
        end
    end

    assign int_out    = int_out_r;
    assign vec_valid  = vec_valid_r;
    assign vec_data   = vec_data_r;
    assign isr        = isr_r;
    assign imr        = imr_r;
    assign poll_valid = poll_valid_r;
    assign poll_data  = poll_data_r;

endmodule
